// File: rtl/riscv_pkg.sv
// Shared RV32I memory-access definitions.
// Used by the data memory and the load/store unit.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        MEM_LOAD  = 1'b0,
        MEM_STORE = 1'b1
    } memory_op_type;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT_RSP,
        LSU_DONE
    } lsu_state_t;

    function automatic logic lsu_fault(
        input logic       is_store,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic legal;
        logic misaligned;
        if (is_store)
            legal = f3 inside {F3_SB, F3_SH, F3_SW};
        else
            legal = f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        misaligned = (f3[1:0] == 2'b01 && off[0])
                  || (f3[1:0] == 2'b10 && off != 2'b00);
        return !legal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store enables/replication
// and load byte/halfword extraction with extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  fun3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    assign byte_sh = rdata >> {offset, 3'b000};
    assign half_sh = rdata >> {offset[1], 4'b0000};

    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        if (is_store) begin
            unique case (fun3[1:0])
                2'b00: begin
                    be         = 4'b0001 << offset;
                    wdata_lane = {4{wdata[7:0]}};
                end
                2'b01: begin
                    be         = 4'b0011 << offset;
                    wdata_lane = {2{wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_ext = rdata;
        unique case (fun3)
            F3_LB:   rdata_ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
            F3_LBU:  rdata_ext = {24'h0, byte_sh[7:0]};
            F3_LH:   rdata_ext = {{16{half_sh[15]}}, half_sh[15:0]};
            F3_LHU:  rdata_ext = {16'h0, half_sh[15:0]};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access,
// req/gnt then rvalid bus handshake, faults complete locally.
module load_store_unit
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic        is_store_i,
    input  logic [2:0]  fun3_i,
    input  logic [31:0] base_i,
    input  logic [31:0] offset_i,
    input  logic [31:0] wdata_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        fault_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    lsu_state_t    state;
    memory_op_type op_q;
    logic [2:0]    fun3_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   addr_sum;
    logic          fault_now;
    logic          is_st;
    logic [3:0]    be_w;
    logic [31:0]   lane_w;
    logic [31:0]   ext_w;

    assign addr_sum  = base_i + offset_i;
    assign fault_now = lsu_fault(is_store_i, fun3_i, addr_sum[1:0]);
    assign is_st     = (op_q == MEM_STORE);

    lsu_align u_align (
        .is_store   (is_st),
        .fun3       (fun3_q),
        .offset     (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (mem_rdata_i),
        .be         (be_w),
        .wdata_lane (lane_w),
        .rdata_ext  (ext_w)
    );

    // Bus outputs are driven from registered state only while requesting
    assign mem_we_o    = mem_req_o & is_st;
    assign mem_addr_o  = mem_req_o ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_be_o    = mem_req_o ? be_w : 4'h0;
    assign mem_wdata_o = mem_we_o ? lane_w : 32'h0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= LSU_IDLE;
            lsu_ready_o <= 1'b1;
            mem_req_o   <= 1'b0;
            done_o      <= 1'b0;
            fault_o     <= 1'b0;
            rdata_o     <= 32'h0;
            op_q        <= MEM_LOAD;
            fun3_q      <= 3'b000;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                LSU_IDLE: begin
                    if (lsu_valid_i) begin
                        op_q        <= is_store_i ? MEM_STORE : MEM_LOAD;
                        fun3_q      <= fun3_i;
                        addr_q      <= addr_sum;
                        wdata_q     <= wdata_i;
                        lsu_ready_o <= 1'b0;
                        if (fault_now) begin
                            state   <= LSU_DONE;
                            done_o  <= 1'b1;
                            fault_o <= 1'b1;
                        end else begin
                            state     <= LSU_REQ;
                            mem_req_o <= 1'b1;
                        end
                    end
                end
                LSU_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state     <= LSU_WAIT_RSP;
                    end
                end
                LSU_WAIT_RSP: begin
                    if (mem_rvalid_i) begin
                        state  <= LSU_DONE;
                        done_o <= 1'b1;
                        if (!is_st)
                            rdata_o <= ext_w;
                    end
                end
                LSU_DONE: begin
                    state       <= LSU_IDLE;
                    lsu_ready_o <= 1'b1;
                    fault_o     <= 1'b0;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic        is_store_i;
    logic [2:0]  fun3_i;
    logic [31:0] base_i;
    logic [31:0] offset_i;
    logic [31:0] wdata_i;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        fault_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] rd_hold = 32'h0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .lsu_valid_i  (lsu_valid_i),
        .lsu_ready_o  (lsu_ready_o),
        .is_store_i   (is_store_i),
        .fun3_i       (fun3_i),
        .base_i       (base_i),
        .offset_i     (offset_i),
        .wdata_i      (wdata_i),
        .done_o       (done_o),
        .rdata_o      (rdata_o),
        .fault_o      (fault_o),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] wd;
        logic [31:0] rsp;
        logic        flt;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] mwd;
        logic [31:0] rd;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input vec_t v);
        chk({tag, " req"}, 32'(mem_req_o), 32'd1);
        chk({tag, " addr"}, mem_addr_o, v.addr);
        chk({tag, " be"}, 32'(mem_be_o), 32'(v.be));
        chk({tag, " we"}, 32'(mem_we_o), 32'(v.st));
        if (v.st)
            chk({tag, " wdata"}, mem_wdata_o, v.mwd);
    endtask

    task automatic do_op(input string tag, input vec_t v,
                         input int gd, input int rd);
        @(negedge clk);
        chk({tag, " ready"}, 32'(lsu_ready_o), 32'd1);
        lsu_valid_i = 1'b1;
        is_store_i  = v.st;
        fun3_i      = v.f3;
        base_i      = v.base;
        offset_i    = v.off;
        wdata_i     = v.wd;
        @(negedge clk);
        lsu_valid_i = 1'b0;
        base_i      = 32'h0;
        offset_i    = 32'h0;
        wdata_i     = 32'h0;
        if (v.flt) begin
            chk({tag, " flt done"}, 32'(done_o), 32'd1);
            chk({tag, " flt fault"}, 32'(fault_o), 32'd1);
            chk({tag, " flt noreq"}, 32'(mem_req_o), 32'd0);
            chk({tag, " flt rdata"}, rdata_o, rd_hold);
        end else begin
            for (int i = 0; i < gd; i++) begin
                chk_bus({tag, " hold"}, v);
                chk({tag, " hold done"}, 32'(done_o), 32'd0);
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = 32'hBAD0BAD0;
                @(negedge clk);
            end
            mem_rvalid_i = 1'b0;
            chk_bus(tag, v);
            mem_gnt_i = 1'b1;
            @(negedge clk);
            mem_gnt_i = (rd > 0);
            chk({tag, " wait noreq"}, 32'(mem_req_o), 32'd0);
            chk({tag, " wait be"}, 32'(mem_be_o), 32'd0);
            for (int i = 0; i < rd; i++) begin
                chk({tag, " wait done"}, 32'(done_o), 32'd0);
                chk({tag, " wait ready"}, 32'(lsu_ready_o), 32'd0);
                @(negedge clk);
            end
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = v.rsp;
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'h0;
            if (!v.st)
                rd_hold = v.rd;
            chk({tag, " done"}, 32'(done_o), 32'd1);
            chk({tag, " fault"}, 32'(fault_o), 32'd0);
            chk({tag, " rdata"}, rdata_o, rd_hold);
        end
        chk({tag, " ready in done"}, 32'(lsu_ready_o), 32'd0);
        @(negedge clk);
        chk({tag, " done pulse"}, 32'(done_o), 32'd0);
        chk({tag, " ready after"}, 32'(lsu_ready_o), 32'd1);
        chk({tag, " rdata hold"}, rdata_o, rd_hold);
    endtask

    initial begin
        tv[0]  = '{1'b1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF, 32'h0,
                   1'b0, 32'h104, 4'b1111, 32'hDEADBEEF, 32'h0};
        tv[1]  = '{1'b1, 3'b000, 32'h200, 32'h3, 32'h000000A5, 32'h0,
                   1'b0, 32'h200, 4'b1000, 32'hA5A5A5A5, 32'h0};
        tv[2]  = '{1'b0, 3'b000, 32'h200, 32'h1, 32'h0, 32'h00008000,
                   1'b0, 32'h200, 4'b1111, 32'h0, 32'hFFFFFF80};
        tv[3]  = '{1'b0, 3'b100, 32'h200, 32'h1, 32'h0, 32'h00008000,
                   1'b0, 32'h200, 4'b1111, 32'h0, 32'h00000080};
        tv[4]  = '{1'b0, 3'b001, 32'h200, 32'h2, 32'h0, 32'h80010000,
                   1'b0, 32'h200, 4'b1111, 32'h0, 32'hFFFF8001};
        tv[5]  = '{1'b0, 3'b010, 32'h100, 32'h2, 32'h0, 32'h0,
                   1'b1, 32'h0, 4'b0, 32'h0, 32'h0};
        tv[6]  = '{1'b0, 3'b010, 32'h300, 32'hFFFFFF04, 32'h0, 32'h12345678,
                   1'b0, 32'h204, 4'b1111, 32'h0, 32'h12345678};
        tv[7]  = '{1'b1, 3'b001, 32'h200, 32'h2, 32'h1234ABCD, 32'h0,
                   1'b0, 32'h200, 4'b1100, 32'hABCDABCD, 32'h0};
        tv[8]  = '{1'b0, 3'b101, 32'h1FF, 32'h1, 32'h0, 32'h1234F00D,
                   1'b0, 32'h200, 4'b1111, 32'h0, 32'h0000F00D};
        tv[9]  = '{1'b1, 3'b001, 32'h200, 32'h1, 32'h5555, 32'h0,
                   1'b1, 32'h0, 4'b0, 32'h0, 32'h0};
        tv[10] = '{1'b0, 3'b011, 32'h200, 32'h0, 32'h0, 32'h0,
                   1'b1, 32'h0, 4'b0, 32'h0, 32'h0};
        tv[11] = '{1'b1, 3'b100, 32'h200, 32'h0, 32'h77, 32'h0,
                   1'b1, 32'h0, 4'b0, 32'h0, 32'h0};
        tv[12] = '{1'b0, 3'b000, 32'h200, 32'h3, 32'h0, 32'h7F000000,
                   1'b0, 32'h200, 4'b1111, 32'h0, 32'h0000007F};

        reset_n      = 1'b0;
        lsu_valid_i  = 1'b0;
        is_store_i   = 1'b0;
        fun3_i       = 3'b000;
        base_i       = 32'h0;
        offset_i     = 32'h0;
        wdata_i      = 32'h0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;

        repeat (2) @(negedge clk);
        chk("rst req", 32'(mem_req_o), 32'd0);
        chk("rst done", 32'(done_o), 32'd0);
        chk("rst fault", 32'(fault_o), 32'd0);
        chk("rst rdata", rdata_o, 32'h0);
        chk("rst addr", mem_addr_o, 32'h0);
        chk("rst be", 32'(mem_be_o), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst ready", 32'(lsu_ready_o), 32'd1);

        for (int i = 0; i < 13; i++)
            do_op($sformatf("vec%0d", i), tv[i], 0, 0);

        do_op("slow sw", tv[0], 3, 2);
        do_op("slow lh", tv[4], 3, 2);

        // Abandon a load in WAIT_RSP via reset
        @(negedge clk);
        lsu_valid_i = 1'b1;
        is_store_i  = 1'b0;
        fun3_i      = 3'b010;
        base_i      = 32'h400;
        offset_i    = 32'h0;
        @(negedge clk);
        lsu_valid_i = 1'b0;
        chk("rr req", 32'(mem_req_o), 32'd1);
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        reset_n   = 1'b0;
        @(negedge clk);
        chk("rr rst req", 32'(mem_req_o), 32'd0);
        chk("rr rst rdata", rdata_o, 32'h0);
        reset_n      = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFEF00D;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rr done", 32'(done_o), 32'd0);
            chk("rr fault", 32'(fault_o), 32'd0);
            chk("rr rdata", rdata_o, 32'h0);
            chk("rr ready", 32'(lsu_ready_o), 32'd1);
            chk("rr req idle", 32'(mem_req_o), 32'd0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: none; address and data are fixed at 32 bits.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 lsu_valid_i  input  1  core request valid.
REQ-005 lsu_ready_o  output  1  unit idle, request accepted when valid&ready.
REQ-006 is_store_i  input  1  1=store, 0=load.
REQ-007 fun3_i  input  3  RV32I width/sign code (LB/LH/LW/LBU/LHU/SB/SH/SW).
REQ-008 base_i, offset_i  input  32 each  address operands.
REQ-009 wdata_i  input  32  store data, low bits significant.
REQ-010 done_o  output  1  one-cycle completion pulse.
REQ-011 rdata_o  output  32  extended load result.
REQ-012 fault_o  output  1  misaligned/illegal fault, valid with done_o.
REQ-013 mem_req_o  output  1  bus request.
REQ-014 mem_gnt_i  input  1  bus grant (request accepted).
REQ-015 mem_we_o  output  1  write enable.
REQ-016 mem_addr_o  output  32  word-aligned address, bits [1:0]=0.
REQ-017 mem_be_o  output  4  byte-lane enables.
REQ-018 mem_wdata_o  output  32  lane-replicated store data.
REQ-019 mem_rvalid_i, mem_rdata_i  input  1, 32  response valid (loads and stores), read data.

Function
REQ-020 FSM states IDLE, REQ, WAIT_RSP, DONE; lsu_ready_o=1 only in IDLE.
REQ-021 On accept, SHALL register op, wdata, and addr=base_i+offset_i modulo 2^32.
REQ-022 Fault: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0, or unsupported fun3; IDLE->DONE, no bus request.
REQ-023 Non-fault: IDLE->REQ; mem_req_o and all mem_* outputs held stable in REQ until mem_gnt_i=1, then ->WAIT_RSP.
REQ-024 WAIT_RSP: on mem_rvalid_i=1 -> DONE, capturing mem_rdata_i for loads.
REQ-025 DONE lasts exactly one cycle with done_o=1, then ->IDLE.
REQ-026 Minimum latency: accept at cycle N, mem_req_o at N+1, gnt at N+1, rvalid at N+2, done_o at N+3; fault done_o at N+1.
REQ-027 mem_be_o: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111; loads 4'b1111.
REQ-028 mem_wdata_o: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
REQ-029 Load extraction selects byte/halfword by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-030 rdata_o updated only at DONE of a non-faulting load; holds until next load completion; stores and faults leave rdata_o unchanged.
REQ-031 mem_gnt_i outside REQ and mem_rvalid_i outside WAIT_RSP SHALL be ignored.
REQ-032 lsu_valid_i while not ready SHALL be ignored; core holds request until accepted.

Reset
REQ-033 reset_n low: state IDLE, all outputs 0 except lsu_ready_o=1 after reset release.
REQ-034 Reset mid-transaction abandons it; a later mem_rvalid_i SHALL be ignored (WAIT_RSP not reached).

Structure
REQ-035 memory_op_type enum and opcode/fun3 constants SHALL live in shared package riscv_pkg, used by both data memory and this block.
REQ-036 Combinational sub-module lsu_align SHALL compute mem_be_o, mem_wdata_o and load extraction.

Verification
REQ-037 SW base=0x100, offset=4, wdata=0xDEADBEEF, gnt immediate -> addr 0x104, be 1111, wdata 0xDEADBEEF, done_o at N+3, fault_o=0.
REQ-038 SB addr 0x203, wdata 0x000000A5 -> addr 0x200, be 1000, wdata 0xA5A5A5A5.
REQ-039 LB addr 0x201, rdata 0x0000_80_00 -> rdata_o 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x202, rdata 0x8001_0000 -> 0xFFFF8001.
REQ-040 LW addr 0x102 -> no mem_req_o, done_o at N+1, fault_o=1, rdata_o unchanged.
REQ-041 Grant withheld 3 cycles, rvalid delayed 2 cycles -> mem_* stable throughout REQ, single done_o pulse, lsu_ready_o low until after DONE.
REQ-042 reset_n asserted in WAIT_RSP, rvalid after release -> IDLE, no done_o, outputs 0.
